// File: rtl/player_tracker.sv
// player_tracker
//   Finds the marker-coloured pixels in each camera frame, averages their
//   coordinates with a sequential restoring divider and publishes the
//   top-left position of the player sprite at every frame end.
//
// Ports
//   clk        camera pixel clock, the only clock
//   reset      asynchronous, active-low reset
//   wren       pixel valid strobe
//   next_x     pixel column (0..639)
//   next_y     pixel row (0..479)
//   rgb        pixel colour, R[8:6] G[5:3] B[2:0]
//   cam_vsync  camera vertical sync, active-high; its rising edge ends a frame
//   posx/posy  published sprite top-left position
//   detected   last completed frame had at least MIN_PIXELS matches
//   pos_valid  one-cycle pulse when a frame result is published
//   busy       high while the centroid divide is running
module player_tracker #(
    parameter int R_MIN      = 5,
    parameter int G_MAX      = 2,
    parameter int B_MAX      = 2,
    parameter int MIN_PIXELS = 64,
    parameter int PLAYER_W   = 32,
    parameter int PLAYER_H   = 16,
    parameter int RESET_X    = 304,
    parameter int RESET_Y    = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wren,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic [8:0] rgb,
    input  logic       cam_vsync,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       detected,
    output logic       pos_valid,
    output logic       busy
);

    typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, UPDATE} state_t;

    localparam logic [2:0]  R_MIN_L  = 3'(R_MIN);
    localparam logic [2:0]  G_MAX_L  = 3'(G_MAX);
    localparam logic [2:0]  B_MAX_L  = 3'(B_MAX);
    localparam logic [18:0] MIN_CNT  = 19'(MIN_PIXELS);
    localparam logic [10:0] HALF_W   = 11'(PLAYER_W / 2);
    localparam logic [10:0] HALF_H   = 11'(PLAYER_H / 2);
    localparam logic [10:0] MAX_X    = 11'(640 - PLAYER_W);
    localparam logic [10:0] MAX_Y    = 11'(480 - PLAYER_H);
    localparam logic [4:0]  LAST_BIT = 5'd27;

    state_t      state_reg;
    logic        vsync_prev_reg;
    logic [27:0] sum_x_reg;
    logic [27:0] sum_y_reg;
    logic [18:0] count_reg;

    // Divider: dq_reg starts as the dividend and fills with quotient bits
    // from the LSB end as the dividend bits shift out of the MSB end.
    logic [27:0] dq_reg;
    logic [18:0] rem_reg;
    logic [18:0] divisor_reg;
    logic [27:0] sum_y_snap_reg;
    logic        enough_reg;
    logic [4:0]  step_reg;
    logic [9:0]  cx_reg;

    logic        pixel_match;
    logic        frame_end;
    logic [19:0] rem_shift;
    logic        quot_bit;
    logic [18:0] rem_next;
    logic [27:0] dq_next;
    logic [10:0] off_x;
    logic [10:0] off_y;
    logic [9:0]  clamp_x;
    logic [9:0]  clamp_y;

    always_comb begin
        pixel_match = wren && (next_x < 10'd640) && (next_y < 10'd480)
                      && (rgb[8:6] >= R_MIN_L) && (rgb[5:3] <= G_MAX_L)
                      && (rgb[2:0] <= B_MAX_L);
        frame_end   = cam_vsync && !vsync_prev_reg;

        // One restoring-divide step. With a zero divisor the result is
        // garbage but finite; it is never published because enough_reg is 0.
        rem_shift = {rem_reg, dq_reg[27]};
        quot_bit  = (rem_shift >= {1'b0, divisor_reg});
        rem_next  = quot_bit ? 19'(rem_shift - {1'b0, divisor_reg}) : rem_shift[18:0];
        dq_next   = {dq_reg[26:0], quot_bit};

        // Centre-to-corner offset in 11-bit signed space; bit 10 set means
        // the centroid sits closer to the edge than half a sprite.
        off_x = {1'b0, cx_reg} - HALF_W;
        off_y = {1'b0, dq_reg[9:0]} - HALF_H;

        clamp_x = off_x[9:0];
        if (off_x[10])
            clamp_x = 10'd0;
        else if (off_x > MAX_X)
            clamp_x = MAX_X[9:0];

        clamp_y = off_y[9:0];
        if (off_y[10])
            clamp_y = 10'd0;
        else if (off_y > MAX_Y)
            clamp_y = MAX_Y[9:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ACCUM;
            vsync_prev_reg <= 1'b0;
            sum_x_reg      <= '0;
            sum_y_reg      <= '0;
            count_reg      <= '0;
            dq_reg         <= '0;
            rem_reg        <= '0;
            divisor_reg    <= '0;
            sum_y_snap_reg <= '0;
            enough_reg     <= 1'b0;
            step_reg       <= '0;
            cx_reg         <= '0;
            posx           <= 10'(RESET_X);
            posy           <= 10'(RESET_Y);
            detected       <= 1'b0;
            pos_valid      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            vsync_prev_reg <= cam_vsync;
            pos_valid      <= 1'b0;

            // Accumulation runs in every state; a frame end always starts a
            // fresh frame, dropping any match that arrives in that cycle.
            if (frame_end) begin
                sum_x_reg <= '0;
                sum_y_reg <= '0;
                count_reg <= '0;
            end else if (pixel_match) begin
                sum_x_reg <= sum_x_reg + 28'(next_x);
                sum_y_reg <= sum_y_reg + 28'(next_y);
                count_reg <= count_reg + 19'd1;
            end

            case (state_reg)
                ACCUM: begin
                    if (frame_end) begin
                        dq_reg         <= sum_x_reg;
                        sum_y_snap_reg <= sum_y_reg;
                        divisor_reg    <= count_reg;
                        enough_reg     <= (count_reg >= MIN_CNT);
                        rem_reg        <= '0;
                        step_reg       <= '0;
                        busy           <= 1'b1;
                        state_reg      <= DIV_X;
                    end
                end
                DIV_X: begin
                    dq_reg   <= dq_next;
                    rem_reg  <= rem_next;
                    step_reg <= step_reg + 5'd1;
                    if (step_reg == LAST_BIT) begin
                        cx_reg    <= dq_next[9:0];
                        dq_reg    <= sum_y_snap_reg;
                        rem_reg   <= '0;
                        step_reg  <= '0;
                        state_reg <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    dq_reg   <= dq_next;
                    rem_reg  <= rem_next;
                    step_reg <= step_reg + 5'd1;
                    if (step_reg == LAST_BIT) begin
                        step_reg  <= '0;
                        state_reg <= UPDATE;
                    end
                end
                UPDATE: begin
                    pos_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ACCUM;
                    if (enough_reg) begin
                        posx     <= clamp_x;
                        posy     <= clamp_y;
                        detected <= 1'b1;
                    end else begin
                        detected <= 1'b0;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_player_tracker.sv
// tb_player_tracker
//   Drives directed and random pixel frames into player_tracker and compares
//   every cycle's outputs with a frame-level reference model (integer sums,
//   integer division, clamping, and a publish scheduled 58 cycles after the
//   accepted vsync rise).
module tb_player_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wren = 1'b0;
    logic [9:0] next_x = '0;
    logic [9:0] next_y = '0;
    logic [8:0] rgb = '0;
    logic       cam_vsync = 1'b0;
    logic [9:0] posx;
    logic [9:0] posy;
    logic       detected;
    logic       pos_valid;
    logic       busy;

    always #5 clk = ~clk;

    player_tracker dut (
        .clk       (clk),
        .reset     (reset),
        .wren      (wren),
        .next_x    (next_x),
        .next_y    (next_y),
        .rgb       (rgb),
        .cam_vsync (cam_vsync),
        .posx      (posx),
        .posy      (posy),
        .detected  (detected),
        .pos_valid (pos_valid),
        .busy      (busy)
    );

    localparam logic [8:0] RED = 9'b111000000;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    longint m_sx, m_sy;
    int     m_cnt;
    bit     m_prev;
    bit     pend;
    int     pend_e;
    bit     pend_ok;
    int     pend_px, pend_py;
    int     exp_px = 304, exp_py = 400;
    bit     exp_det, exp_pv, exp_busy;
    int     n_pub = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_match(input bit w, input int x, input int y, input logic [8:0] c);
        return w && x < 640 && y < 480 && c[8:6] >= 5 && c[5:3] <= 2 && c[2:0] <= 2;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check_outputs();
        check_val("pos_valid", 32'(pos_valid), int'(exp_pv));
        check_val("busy", 32'(busy), int'(exp_busy));
        check_val("posx", 32'(posx), exp_px);
        check_val("posy", 32'(posy), exp_py);
        check_val("detected", 32'(detected), int'(exp_det));
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_cnt = 0; m_prev = 0;
        pend = 0; exp_pv = 0; exp_busy = 0;
        exp_px = 304; exp_py = 400; exp_det = 0;
    endtask

    // One pixel-clock cycle: inputs applied just after the edge, outputs
    // checked on the falling edge.
    task automatic drive_cycle(input bit w, input int x, input int y,
                               input logic [8:0] c, input bit vs);
        bit ev;
        @(posedge clk);
        cyc++;
        exp_pv = 0;
        if (pend && cyc == pend_e + 58) begin
            exp_pv = 1;
            pend   = 0;
            n_pub++;
            if (pend_ok) begin
                exp_px  = pend_px;
                exp_py  = pend_py;
                exp_det = 1;
            end else begin
                exp_det = 0;
            end
        end
        exp_busy = pend && cyc >= pend_e + 1;
        #1;
        wren = w; next_x = x[9:0]; next_y = y[9:0]; rgb = c; cam_vsync = vs;
        ev = vs && !m_prev;
        if (ev) begin
            if (!exp_busy) begin
                pend    = 1;
                pend_e  = cyc;
                pend_ok = m_cnt >= 64;
                if (pend_ok) begin
                    pend_px = clampi(int'(m_sx / m_cnt) - 16, 608);
                    pend_py = clampi(int'(m_sy / m_cnt) - 8, 464);
                end
                $display("frame end at cycle %0d: count=%0d sum_x=%0d sum_y=%0d", cyc, m_cnt, m_sx, m_sy);
            end else begin
                $display("frame end at cycle %0d while busy: %0d pixels dropped", cyc, m_cnt);
            end
            m_sx = 0; m_sy = 0; m_cnt = 0;
        end else if (is_match(w, x, y, c)) begin
            m_sx += x; m_sy += y; m_cnt++;
        end
        m_prev = vs;
        @(negedge clk);
        check_outputs();
        if (exp_pv)
            $display("publish at cycle %0d: posx=%0d posy=%0d detected=%0d (expected %0d %0d %0d)",
                     cyc, posx, posy, detected, exp_px, exp_py, exp_det);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 9'd0, 0);
    endtask

    task automatic pulse_vsync(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 9'd0, 1);
    endtask

    task automatic send_block(input int x0, input int y0, input int w, input int h,
                              input logic [8:0] c);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                drive_cycle(1, x, y, c, 0);
    endtask

    // Asserts reset just after an edge and checks the outputs return to
    // their reset values before the next edge arrives.
    task automatic apply_reset(input int n);
        @(posedge clk);
        cyc++;
        #1;
        reset = 0; wren = 0; cam_vsync = 0;
        model_reset();
        #1;
        check_outputs();
        $display("reset asserted at cycle %0d", cyc);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_outputs();
        end
        reset = 1;
    endtask

    task automatic random_frame();
        int w, h, x0, y0, n_extra;
        logic [8:0] c;
        w  = $urandom_range(4, 16);
        h  = $urandom_range(4, 16);
        x0 = $urandom_range(0, 650);
        y0 = $urandom_range(0, 490);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++) begin
                if ($urandom_range(0, 1) == 1)
                    c = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 3'($urandom_range(0, 2))};
                else
                    c = 9'($urandom);
                drive_cycle($urandom_range(0, 9) != 0, x, y, c, 0);
            end
        n_extra = $urandom_range(0, 20);
        for (int i = 0; i < n_extra; i++)
            drive_cycle(1, $urandom_range(0, 1023), $urandom_range(0, 1023), 9'($urandom), 0);
        pulse_vsync($urandom_range(1, 6));
        idle($urandom_range(10, 70));
    endtask

    initial begin
        model_reset();
        apply_reset(3);
        idle(100);

        // Centred block: expect 99/199 detected
        send_block(100, 200, 32, 16, RED);
        pulse_vsync(4);
        idle(70);

        // Too few pixels: position holds, detected drops
        send_block(100, 200, 10, 5, RED);
        pulse_vsync(4);
        idle(70);

        // Corner block: clamps to 0/464
        send_block(0, 470, 8, 10, RED);
        pulse_vsync(4);
        idle(70);

        // Non-matching colours only
        for (int i = 0; i < 200; i++)
            drive_cycle(1, 200 + (i % 20), 100 + (i / 20), (i % 2 == 0) ? 9'b111111111 : 9'b100000000, 0);
        pulse_vsync(4);
        idle(70);

        // Second vsync rise at E+20 while dividing, with pixels in between
        send_block(300, 100, 16, 8, RED);
        pulse_vsync(10);
        send_block(400, 300, 10, 1, RED);
        pulse_vsync(5);
        send_block(50, 50, 10, 1, RED);
        idle(60);
        send_block(500, 300, 12, 8, RED);
        pulse_vsync(3);
        idle(70);

        // Reset at E+40 aborts the divide with no publish
        send_block(200, 240, 16, 8, RED);
        pulse_vsync(5);
        idle(35);
        apply_reset(2);
        idle(80);

        for (int f = 0; f < 14; f++) random_frame();
        idle(70);

        check_val("publish_count", 32'(n_pub > 8), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
